// File: rtl/stratego_board_engine.sv
// ---------------------------------------------------------------------------
// stratego_board_engine
//   Board-state engine for Stratego. Holds the board, runs roster placement
//   for both teams, validates select/target gos, resolves combat by rank and
//   tracks turn and game-over.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   cur_x/cur_y, go      cursor cell and one-cycle action pulse
//   rd_x/rd_y, rd_code   registered render read port (1-cycle latency)
//   board                flat board, cell (x,y) at (x+y*COLS)*CODE_W
//   phase, turn          FSM phase and team to move
//   piece_idx            next roster entry during setup
//   sel_x/sel_y          latched source cell
//   err                  one-cycle pulse on a rejected go
//   last_result          last combat outcome (move/capture/dies/trade)
//   win_flag, winner     game over and winning team
// ---------------------------------------------------------------------------
module stratego_board_engine #(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int CODE_W     = 6,
    parameter int SETUP_ROWS = 7,
    parameter logic [COLS*ROWS-1:0] LAKE_MASK = 64'h0000_0018_1800_0000,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [XW-1:0]                 cur_x,
    input  logic [YW-1:0]                 cur_y,
    input  logic                          go,
    input  logic [XW-1:0]                 rd_x,
    input  logic [YW-1:0]                 rd_y,
    output logic [CODE_W-1:0]             rd_code,
    output logic [COLS*ROWS*CODE_W-1:0]   board,
    output logic [2:0]                    phase,
    output logic                          turn,
    output logic [3:0]                    piece_idx,
    output logic [XW-1:0]                 sel_x,
    output logic [YW-1:0]                 sel_y,
    output logic                          err,
    output logic [1:0]                    last_result,
    output logic                          win_flag,
    output logic                          winner
);

    localparam int NCELL = COLS * ROWS;
    localparam int CW    = XW + YW;      // cell index width
    localparam int KW    = CODE_W - 1;   // kind width

    localparam logic [KW-1:0] K_F   = KW'(1);
    localparam logic [KW-1:0] K_B   = KW'(2);
    localparam logic [KW-1:0] K_S   = KW'(3);
    localparam logic [KW-1:0] K_2   = KW'(4);
    localparam logic [KW-1:0] K_3   = KW'(5);
    localparam logic [KW-1:0] K_9   = KW'(6);
    localparam logic [KW-1:0] K_10  = KW'(7);

    localparam logic [1:0] R_MOVE  = 2'd0;
    localparam logic [1:0] R_CAP   = 2'd1;
    localparam logic [1:0] R_DIE   = 2'd2;
    localparam logic [1:0] R_TRADE = 2'd3;

    typedef enum logic [2:0] {
        P_SETUP0  = 3'd0,
        P_SETUP1  = 3'd1,
        P_SEL     = 3'd2,
        P_DST     = 3'd3,
        P_RESOLVE = 3'd4,
        P_WRITE   = 3'd5,
        P_OVER    = 3'd7
    } phase_e;

    // Index is formed at full width (x + y*COLS), then trimmed to the array range.
    function automatic logic [CW-1:0] cidx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [CW:0] xe;
        logic [CW:0] ye;
        xe = (CW+1)'(x);
        ye = (CW+1)'(y);
        return CW'(xe + ye * (CW+1)'(COLS));
    endfunction

    function automatic logic [KW-1:0] roster(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: roster = K_2;
            4'd2, 4'd3: roster = K_3;
            4'd4:       roster = K_9;
            4'd5:       roster = K_10;
            4'd6:       roster = K_S;
            4'd7, 4'd8: roster = K_B;
            default:    roster = K_F;
        endcase
    endfunction

    function automatic logic [3:0] strength(input logic [KW-1:0] k);
        case (k)
            K_S:     strength = 4'd1;
            K_2:     strength = 4'd2;
            K_3:     strength = 4'd3;
            K_9:     strength = 4'd9;
            K_10:    strength = 4'd10;
            default: strength = 4'd0;
        endcase
    endfunction

    function automatic logic is_lake(input logic [CODE_W-1:0] c);
        return &c;
    endfunction

    function automatic logic is_movable(input logic [CODE_W-1:0] c);
        logic [KW-1:0] k;
        k = c[KW-1:0];
        return !is_lake(c) && (k == K_S || k == K_2 || k == K_3 || k == K_9 || k == K_10);
    endfunction

    // State
    phase_e                       phase_q, phase_d;
    logic [NCELL-1:0][CODE_W-1:0] cells_q, cells_d;
    logic                         turn_q, turn_d;
    logic [3:0]                   pidx_q, pidx_d;
    logic [XW-1:0]                sel_x_q, sel_x_d, dst_x_q, dst_x_d;
    logic [YW-1:0]                sel_y_q, sel_y_d, dst_y_q, dst_y_d;
    logic                         err_q, err_d;
    logic [1:0]                   lr_q, lr_d;
    logic [1:0]                   res_q, res_d;
    logic                         wpend_q, wpend_d;
    logic                         win_q, win_d;
    logic                         winner_q, winner_d;
    logic [CODE_W-1:0]            rd_code_q;

    // Cell views
    logic [CW-1:0]     cur_i, sel_i, dst_i, rd_i;
    logic [CODE_W-1:0] cur_c, atk_c, def_c;
    logic [KW-1:0]     atk_k, def_k;
    logic              in_left, in_rows, zone_ok, setup_team;
    logic [XW:0]       dx;
    logic [YW:0]       dy;
    logic              adjacent;

    assign cur_i = cidx(cur_x, cur_y);
    assign sel_i = cidx(sel_x_q, sel_y_q);
    assign dst_i = cidx(dst_x_q, dst_y_q);
    assign rd_i  = cidx(rd_x, rd_y);

    assign cur_c = cells_q[cur_i];
    assign atk_c = cells_q[sel_i];
    assign def_c = cells_q[dst_i];
    assign atk_k = atk_c[KW-1:0];
    assign def_k = def_c[KW-1:0];

    assign in_left    = {1'b0, cur_x} < (XW+1)'(COLS / 2);
    assign in_rows    = {1'b0, cur_y} < (YW+1)'(SETUP_ROWS);
    assign setup_team = (phase_q == P_SETUP1);
    assign zone_ok    = in_rows && (setup_team ? !in_left : in_left);

    // Distances at one extra bit so edge cells never wrap. The cursor itself
    // is always in bounds since COLS/ROWS are powers of two.
    assign dx = (cur_x >= sel_x_q) ? ({1'b0, cur_x} - {1'b0, sel_x_q})
                                   : ({1'b0, sel_x_q} - {1'b0, cur_x});
    assign dy = (cur_y >= sel_y_q) ? ({1'b0, cur_y} - {1'b0, sel_y_q})
                                   : ({1'b0, sel_y_q} - {1'b0, cur_y});
    assign adjacent = ((dx == (XW+1)'(1)) && (dy == '0)) ||
                      ((dx == '0) && (dy == (YW+1)'(1)));

    always_comb begin
        phase_d  = phase_q;
        cells_d  = cells_q;
        turn_d   = turn_q;
        pidx_d   = pidx_q;
        sel_x_d  = sel_x_q;
        sel_y_d  = sel_y_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        err_d    = 1'b0;
        lr_d     = lr_q;
        res_d    = res_q;
        wpend_d  = wpend_q;
        win_d    = win_q;
        winner_d = winner_q;

        unique case (phase_q)
            P_SETUP0, P_SETUP1: begin
                if (go) begin
                    if (zone_ok && (cur_c == '0)) begin
                        cells_d[cur_i] = {setup_team, roster(pidx_q)};
                        if (pidx_q == 4'd9) begin
                            pidx_d  = 4'd0;
                            phase_d = setup_team ? P_SEL : P_SETUP1;
                            turn_d  = 1'b0;
                        end else begin
                            pidx_d = pidx_q + 4'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            P_SEL: begin
                if (go) begin
                    if (is_movable(cur_c) && (cur_c[CODE_W-1] == turn_q)) begin
                        sel_x_d = cur_x;
                        sel_y_d = cur_y;
                        phase_d = P_DST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            P_DST: begin
                if (go) begin
                    if ((cur_x == sel_x_q) && (cur_y == sel_y_q)) begin
                        phase_d = P_SEL;
                    end else if (adjacent && !is_lake(cur_c) &&
                                 !((cur_c != '0) && (cur_c[CODE_W-1] == turn_q))) begin
                        dst_x_d = cur_x;
                        dst_y_d = cur_y;
                        phase_d = P_RESOLVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            P_RESOLVE: begin
                wpend_d = 1'b0;
                if (def_c == '0) begin
                    res_d = R_MOVE;
                end else if (def_k == K_F) begin
                    res_d   = R_CAP;
                    wpend_d = 1'b1;
                end else if (def_k == K_B) begin
                    res_d = (atk_k == K_3) ? R_CAP : R_DIE;
                end else if ((atk_k == K_S) && (def_k == K_10)) begin
                    res_d = R_CAP;
                end else if (strength(atk_k) > strength(def_k)) begin
                    res_d = R_CAP;
                end else if (strength(atk_k) < strength(def_k)) begin
                    res_d = R_DIE;
                end else begin
                    res_d = R_TRADE;
                end
                phase_d = P_WRITE;
            end
            P_WRITE: begin
                case (res_q)
                    R_MOVE, R_CAP: begin
                        cells_d[dst_i] = atk_c;
                        cells_d[sel_i] = '0;
                    end
                    R_DIE: cells_d[sel_i] = '0;
                    default: begin
                        cells_d[sel_i] = '0;
                        cells_d[dst_i] = '0;
                    end
                endcase
                lr_d = res_q;
                if (wpend_q) begin
                    win_d    = 1'b1;
                    winner_d = turn_q;
                    phase_d  = P_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    phase_d = P_SEL;
                end
            end
            P_OVER: ;
            default: phase_d = P_OVER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NCELL; i++) begin
                cells_q[i] <= LAKE_MASK[i] ? {CODE_W{1'b1}} : {CODE_W{1'b0}};
            end
            phase_q   <= P_SETUP0;
            turn_q    <= 1'b0;
            pidx_q    <= 4'd0;
            sel_x_q   <= '0;
            sel_y_q   <= '0;
            dst_x_q   <= '0;
            dst_y_q   <= '0;
            err_q     <= 1'b0;
            lr_q      <= 2'd0;
            res_q     <= 2'd0;
            wpend_q   <= 1'b0;
            win_q     <= 1'b0;
            winner_q  <= 1'b0;
            rd_code_q <= '0;
        end else begin
            cells_q   <= cells_d;
            phase_q   <= phase_d;
            turn_q    <= turn_d;
            pidx_q    <= pidx_d;
            sel_x_q   <= sel_x_d;
            sel_y_q   <= sel_y_d;
            dst_x_q   <= dst_x_d;
            dst_y_q   <= dst_y_d;
            err_q     <= err_d;
            lr_q      <= lr_d;
            res_q     <= res_d;
            wpend_q   <= wpend_d;
            win_q     <= win_d;
            winner_q  <= winner_d;
            // Samples the pre-edge board: a write is seen one cycle later.
            rd_code_q <= cells_q[rd_i];
        end
    end

    assign board       = cells_q;
    assign rd_code     = rd_code_q;
    assign phase       = phase_q;
    assign turn        = turn_q;
    assign piece_idx   = pidx_q;
    assign sel_x       = sel_x_q;
    assign sel_y       = sel_y_q;
    assign err         = err_q;
    assign last_result = lr_q;
    assign win_flag    = win_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_stratego_board_engine.sv
// ---------------------------------------------------------------------------
// tb_stratego_board_engine
//   Directed bench: reset, both setups, selection/target rejects, each combat
//   outcome, flag capture, game-over gating and reset recovery. Expected board
//   contents are tracked by hand in exp_b.
// ---------------------------------------------------------------------------
module tb_stratego_board_engine;

    localparam logic [63:0] LAKES = 64'h0000_0018_1800_0000;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [2:0]   cur_x = '0, cur_y = '0, rd_x = '0, rd_y = '0;
    logic         go = 1'b0;
    logic [5:0]   rd_code;
    logic [383:0] board;
    logic [2:0]   phase;
    logic         turn;
    logic [3:0]   piece_idx;
    logic [2:0]   sel_x, sel_y;
    logic         err;
    logic [1:0]   last_result;
    logic         win_flag, winner;

    int tests = 0;
    int fails = 0;
    logic [63:0][5:0] exp_b;

    // Placement tables, roster order K2,K2,K3,K3,K9,K10,S,B,B,F
    int kind [10] = '{4, 4, 5, 5, 6, 7, 3, 2, 2, 1};
    int t0x  [10] = '{0, 3, 3, 0, 3, 0, 2, 1, 3, 0};
    int t0y  [10] = '{0, 6, 1, 1, 2, 2, 2, 1, 5, 3};
    int t1x  [10] = '{7, 7, 4, 4, 7, 4, 7, 7, 7, 4};
    int t1y  [10] = '{0, 1, 1, 5, 2, 2, 3, 4, 5, 6};

    stratego_board_engine dut (
        .clk(clk), .resetn(resetn), .cur_x(cur_x), .cur_y(cur_y), .go(go),
        .rd_x(rd_x), .rd_y(rd_y), .rd_code(rd_code), .board(board),
        .phase(phase), .turn(turn), .piece_idx(piece_idx), .sel_x(sel_x),
        .sel_y(sel_y), .err(err), .last_result(last_result),
        .win_flag(win_flag), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_board(input string tag);
        tests++;
        assert (board === exp_b) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, board, exp_b);
        end
    endtask

    task automatic set_cell(input int x, input int y, input int code);
        exp_b[x + y * 8] = 6'(code);
    endtask

    task automatic reset_board;
        for (int i = 0; i < 64; i++) exp_b[i] = LAKES[i] ? 6'h3F : 6'h00;
    endtask

    task automatic do_go(input int x, input int y);
        cur_x = 3'(x);
        cur_y = 3'(y);
        go    = 1'b1;
        tick();
        go    = 1'b0;
    endtask

    // select, target, then RESOLVE and WRITE edges
    task automatic attack(input int sx, input int sy, input int dx, input int dy);
        do_go(sx, sy);
        do_go(dx, dy);
        tick();
        tick();
    endtask

    initial begin
        reset_board();
        resetn = 1'b0;
        tick();
        tick();
        chk("rst_rd_code", 32'(rd_code), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_piece_idx", 32'(piece_idx), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_win", 32'(win_flag), 0);
        chk_board("rst_board");

        resetn = 1'b1;
        rd_x = 3; rd_y = 3;
        tick();
        chk("rd_lake_33", 32'(rd_code), 'h3F);
        rd_x = 0; rd_y = 0;
        tick();
        chk("rd_empty_00", 32'(rd_code), 0);

        // ---- SETUP0 ----
        do_go(0, 0);
        set_cell(0, 0, 'h04);
        chk("s0_first_err", 32'(err), 0);
        chk("s0_first_idx", 32'(piece_idx), 1);
        chk("s0_rd_not_yet", 32'(rd_code), 0);
        chk_board("s0_first_board");
        do_go(0, 0);
        chk("s0_occupied_err", 32'(err), 1);
        chk("s0_occupied_idx", 32'(piece_idx), 1);
        chk("s0_rd_visible", 32'(rd_code), 'h04);
        tick();
        chk("s0_err_one_cycle", 32'(err), 0);
        do_go(5, 0);
        chk("s0_zone_err", 32'(err), 1);
        chk_board("s0_zone_board");
        do_go(0, 7);
        chk("s0_row7_err", 32'(err), 1);
        do_go(3, 3);
        chk("s0_lake_err", 32'(err), 1);
        tick();
        for (int i = 1; i < 10; i++) begin
            do_go(t0x[i], t0y[i]);
            set_cell(t0x[i], t0y[i], kind[i]);
        end
        chk("s0_done_phase", 32'(phase), 1);
        chk("s0_done_idx", 32'(piece_idx), 0);
        chk_board("s0_done_board");

        // ---- SETUP1 ----
        do_go(2, 0);
        chk("s1_zone_err", 32'(err), 1);
        do_go(4, 7);
        chk("s1_row7_err", 32'(err), 1);
        for (int i = 0; i < 10; i++) begin
            do_go(t1x[i], t1y[i]);
            set_cell(t1x[i], t1y[i], 'h20 + kind[i]);
        end
        chk("s1_done_phase", 32'(phase), 2);
        chk("s1_done_turn", 32'(turn), 0);
        chk_board("s1_done_board");

        // ---- SEL / DST rejects and cancel ----
        do_go(1, 1);
        chk("sel_bomb_err", 32'(err), 1);
        chk("sel_bomb_phase", 32'(phase), 2);
        do_go(4, 1);
        chk("sel_enemy_err", 32'(err), 1);
        do_go(0, 0);
        chk("sel_k2_phase", 32'(phase), 3);
        chk("sel_k2_err", 32'(err), 0);
        chk("sel_k2_xy", 32'({sel_x, sel_y}), 0);
        do_go(2, 0);
        chk("dst_dist2_err", 32'(err), 1);
        chk("dst_dist2_phase", 32'(phase), 3);
        do_go(0, 1);
        chk("dst_own_err", 32'(err), 1);
        do_go(0, 0);
        chk("dst_cancel_phase", 32'(phase), 2);
        chk("dst_cancel_err", 32'(err), 0);

        // ---- K9 attacks K10: attacker dies ----
        do_go(3, 2);
        chk("k9_sel_xy", 32'({sel_x, sel_y}), 'h1A);
        do_go(3, 3);
        chk("dst_lake_err", 32'(err), 1);
        do_go(4, 1);
        chk("dst_diag_err", 32'(err), 1);
        do_go(4, 2);
        chk("k9_resolve_phase", 32'(phase), 4);
        chk("k9_accept_err", 32'(err), 0);
        do_go(3, 2);
        chk("k9_write_phase", 32'(phase), 5);
        chk("resolve_go_no_err", 32'(err), 0);
        chk_board("k9_board_unchanged");
        tick();
        set_cell(3, 2, 0);
        chk_board("k9_dies_board");
        chk("k9_dies_lr", 32'(last_result), 2);
        chk("k9_dies_turn", 32'(turn), 1);
        chk("k9_dies_phase", 32'(phase), 2);
        rd_x = 4; rd_y = 2;
        tick();
        chk("rd_k10", 32'(rd_code), 'h27);

        // ---- K3 vs K3: trade ----
        attack(4, 1, 3, 1);
        set_cell(4, 1, 0);
        set_cell(3, 1, 0);
        chk_board("trade_board");
        chk("trade_lr", 32'(last_result), 3);
        chk("trade_turn", 32'(turn), 0);

        // ---- S steps into empty cell: move ----
        attack(2, 2, 3, 2);
        set_cell(2, 2, 0);
        set_cell(3, 2, 'h03);
        chk_board("move_board");
        chk("move_lr", 32'(last_result), 0);
        chk("move_turn", 32'(turn), 1);

        // ---- team 1 K3 on team 0 B: capture ----
        attack(4, 5, 3, 5);
        set_cell(4, 5, 0);
        set_cell(3, 5, 'h25);
        chk_board("k3_bomb_board");
        chk("k3_bomb_lr", 32'(last_result), 1);
        chk("k3_bomb_turn", 32'(turn), 0);

        // ---- S on K10: capture ----
        attack(3, 2, 4, 2);
        set_cell(3, 2, 0);
        set_cell(4, 2, 'h03);
        chk_board("spy_board");
        chk("spy_lr", 32'(last_result), 1);
        chk("spy_turn", 32'(turn), 1);

        // ---- team 1 edge-column move ----
        attack(7, 0, 6, 0);
        set_cell(7, 0, 0);
        set_cell(6, 0, 'h24);
        chk_board("t1_move_board");
        chk("t1_move_turn", 32'(turn), 0);

        // ---- K2 takes the flag ----
        attack(3, 6, 4, 6);
        set_cell(3, 6, 0);
        set_cell(4, 6, 'h04);
        chk_board("flag_board");
        chk("flag_lr", 32'(last_result), 1);
        chk("flag_win", 32'(win_flag), 1);
        chk("flag_winner", 32'(winner), 0);
        chk("flag_phase", 32'(phase), 7);
        chk("flag_turn", 32'(turn), 0);
        do_go(0, 2);
        chk("over_go_err", 32'(err), 0);
        chk("over_go_phase", 32'(phase), 7);
        chk_board("over_go_board");

        // ---- reset from OVER ----
        rd_x = 3; rd_y = 3;
        resetn = 1'b0;
        tick();
        reset_board();
        chk("rst2_rd_code", 32'(rd_code), 0);
        chk("rst2_phase", 32'(phase), 0);
        chk("rst2_win", 32'(win_flag), 0);
        chk("rst2_lr", 32'(last_result), 0);
        chk_board("rst2_board");
        resetn = 1'b1;
        tick();
        chk("rst2_rd_lake", 32'(rd_code), 'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stratego_board_engine.md
Name: stratego_board_engine

Overview:
- Parametrised board-state engine for the Stratego game: it stores the board, runs piece placement for both teams, and validates moves.
- It resolves combat internally by comparing ranks. No external capture command is needed.
- It tracks the turn and raises the win flag.
- It sits between the cursor/button front end and the VGA renderer. The renderer reads cells through a registered read port or the flat board bus.

Parameters:
- COLS, 8, board width in cells (power of two, ≥4)
- ROWS, 8, board height in cells (power of two, ≥2)
- CODE_W, 6, bits per cell code: MSB is the team, low CODE_W-1 bits are the kind (≥5)
- SETUP_ROWS, 7, rows 0..SETUP_ROWS-1 are legal for placement
- LAKE_MASK, 64'h0000_0018_1800_0000, COLS*ROWS bits; bit x+y*COLS set means the cell is impassable

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- cur_x  in  XW=$clog2(COLS)  cursor column
- cur_y  in  YW=$clog2(ROWS)  cursor row
- go  in  1  one-cycle pulse from an upstream edge detector; act on the cursor cell
- rd_x  in  XW  render read column
- rd_y  in  YW  render read row
- rd_code  out  CODE_W  code of cell (rd_x,rd_y), 1-cycle latency
- board  out  COLS*ROWS*CODE_W  flat board; cell (x,y) is at bits (x+y*COLS)*CODE_W +: CODE_W
- phase  out  3  0 SETUP0, 1 SETUP1, 2 SEL, 3 DST, 4 RESOLVE, 5 WRITE, 7 OVER
- turn  out  1  team to move
- piece_idx  out  4  index of the next roster piece during setup
- sel_x  out  XW  latched source column
- sel_y  out  YW  latched source row
- err  out  1  one-cycle pulse when a go is rejected
- last_result  out  2  outcome of the last combat: 0 move, 1 capture, 2 attacker dies, 3 trade
- win_flag  out  1  game over
- winner  out  1  winning team, valid while win_flag=1

Behaviour:
- Cell codes:
  - all-zero = empty; all-ones = lake.
  - Kinds: F=1, B=2, S=3, K2=4, K3=5, K9=6, K10=7.
  - Strength: S=1, K2=2, K3=3, K9=9, K10=10.
  - F and B never move.
- Reset (resetn=0 at a clk edge), from any state including mid-move:
  - Board: lake cells = all-ones, all other cells = 0.
  - phase=SETUP0; turn, piece_idx, sel_x, sel_y, err, last_result, win_flag, winner all = 0.
  - rd_code=0 on the next cycle.
- Roster, indexed by piece_idx 0..9: K2, K2, K3, K3, K9, K10, S, B, B, F.
- SETUP0: a go is accepted when all of the following hold:
  - cur_x < COLS/2 and cur_y < SETUP_ROWS;
  - the cell is empty (lake cells are never empty).
- On acceptance:
  - write {1'b0, roster[piece_idx]} to the cell and increment piece_idx;
  - on the write for idx 9: piece_idx←0 and phase←SETUP1.
  - Any other go pulses err and changes nothing.
- SETUP1: same as SETUP0 with team bit 1, zone cur_x ≥ COLS/2. After idx 9: phase←SEL, turn=0.
- SEL: a go is accepted when the cursor cell holds a movable piece of team `turn`.
  - Accept: latch sel_x/sel_y, phase←DST.
  - Otherwise: pulse err, stay in SEL.
- DST, go handling:
  - Cursor equals sel: cancel, phase←SEL, no err.
  - Legal target: Manhattan distance 1, in bounds, not a lake, not an own-team piece. Latch the target, phase←RESOLVE.
  - Anything else: pulse err, stay in DST.
- RESOLVE (1 cycle), registered outcome:
  - target empty → move;
  - defender F → capture and set the win-pending flag;
  - defender B → capture if attacker is K3, else attacker dies;
  - attacker S and defender K10 → capture;
  - otherwise compare strength: higher → capture, lower → attacker dies, equal → trade.
- WRITE (1 cycle):
  - move/capture: target←attacker, source←0;
  - attacker dies: source←0;
  - trade: both cells←0;
  - last_result updated.
  - If win-pending: win_flag←1, winner←turn, phase←OVER.
  - Otherwise: turn toggles, phase←SEL.
- Latency: go accepted at edge N in DST → board, turn and phase updated at edge N+2.
- Gating: go is ignored without err in RESOLVE and WRITE. In OVER, go is ignored and only reset exits.
- err: high exactly one cycle per rejected go, never two consecutive cycles from a single pulse.
- Read port: rd_code is registered from the current board, so a write at edge N is visible on rd_code at edge N+1 when read that cycle.
- Coordinate arithmetic:
  - done at XW+1 / YW+1 bits so edge cells never wrap;
  - the cell index is computed as x + y*COLS at full width before the multiply by CODE_W.

Test Plan:
- Reset, read (3,3) and (0,0) → rd_code 6'h3F and 6'h00; phase=0, board lake bits match LAKE_MASK.
- SETUP0: go at (0,0), then go again at (0,0) → (0,0)=6'h04, piece_idx=1, second go gives err=1 for one cycle; go at (5,0) → err, board unchanged.
- Complete both setups (20 legal gos) → phase=2, turn=0, 20 cells hold roster codes; a go at (0,7) during setup → err.
- SEL on own B → err. Select own K2 then target a diagonal or lake-adjacent lake cell → err in DST. Go on sel → back to SEL.
- K9 (team 0) attacks adjacent team 1 K10 → after 2 cycles source=0, target unchanged, last_result=2, turn=1. Equal K3 vs K3 → both cells 0, last_result=3.
- Team 0 S attacks team 1 K10 → capture. Team 1 K3 attacks team 0 B → capture. Any piece captures F → win_flag=1, winner=capturing team, phase=7. Later go ignored, resetn=0 restores the reset board.
